// File: rtl/rom_rr_arbiter_pkg.sv
// Shared definitions for the ROM round-robin arbiter: default widths and FSM encoding.
// Encoding 2'd3 is unused and recovers to IDLE.
package rom_rr_arbiter_pkg;

  localparam int ADDR_W_DEF = 4;
  localparam int DATA_W_DEF = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_READ = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/rom_rr_arbiter_if.sv
// Requester, response and ROM-side signals of the arbiter.
// slave = arbiter view, master = environment (requesters plus ROM).
interface rom_rr_arbiter_if
  import rom_rr_arbiter_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) ();

  logic              req0;
  logic [ADDR_W-1:0] addr0;
  logic              req1;
  logic [ADDR_W-1:0] addr1;
  logic              ack0;
  logic              ack1;
  logic [DATA_W-1:0] rdata;
  logic              busy;
  logic [ADDR_W-1:0] rom_addr;
  logic              rom_cs;
  logic              rom_rd_en;
  logic [DATA_W-1:0] rom_data;

  modport slave (
    input  req0, addr0, req1, addr1, rom_data,
    output ack0, ack1, rdata, busy, rom_addr, rom_cs, rom_rd_en
  );

  modport master (
    output req0, addr0, req1, addr1, rom_data,
    input  ack0, ack1, rdata, busy, rom_addr, rom_cs, rom_rd_en
  );

endinterface

// File: rtl/rom_rr_arbiter_rr_arb2.sv
// Combinational two-way round-robin pick: on a tie the requester that did
// not win last time is chosen.
module rr_arb2 (
  input  logic req0_i,
  input  logic req1_i,
  input  logic last_grant_i,
  output logic gnt_valid_o,
  output logic gnt_id_o
);

  always_comb begin
    gnt_valid_o = req0_i | req1_i;
    gnt_id_o    = 1'b0;
    if (req0_i && req1_i) begin
      gnt_id_o = ~last_grant_i;
    end else if (req1_i) begin
      gnt_id_o = 1'b1;
    end
  end

endmodule

// File: rtl/rom_rr_arbiter.sv
// Two-requester round-robin read sequencer in front of a shared async-read ROM.
// One read per grant: READ drives the ROM for one cycle, DONE returns data with an ack.
//
//   state | meaning
//   IDLE  | arbitrate; latch winner id and address on a grant
//   READ  | rom_cs/rom_rd_en high, capture rom_data at the edge
//   DONE  | ack pulse for the granted requester, rdata valid, reqs ignored
module rom_rr_arbiter
  import rom_rr_arbiter_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic clk,
  input  logic rst,
  rom_rr_arbiter_if.slave bus
);

  state_e            state_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] rdata_q;
  logic              gnt_id_q;
  logic              last_grant_q;

  logic gnt_valid;
  logic gnt_id;

  rr_arb2 u_rr_arb2 (
    .req0_i       (bus.req0),
    .req1_i       (bus.req1),
    .last_grant_i (last_grant_q),
    .gnt_valid_o  (gnt_valid),
    .gnt_id_o     (gnt_id)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      addr_q       <= '0;
      rdata_q      <= '0;
      gnt_id_q     <= 1'b0;
      last_grant_q <= 1'b1;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (gnt_valid) begin
            gnt_id_q     <= gnt_id;
            last_grant_q <= gnt_id;
            addr_q       <= gnt_id ? bus.addr1 : bus.addr0;
            state_q      <= ST_READ;
          end
        end
        ST_READ: begin
          rdata_q <= bus.rom_data;
          state_q <= ST_DONE;
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  // Outputs decode registered state only, so no request reaches an output combinationally.
  assign bus.rom_cs    = (state_q == ST_READ);
  assign bus.rom_rd_en = (state_q == ST_READ);
  assign bus.rom_addr  = addr_q;
  assign bus.ack0      = (state_q == ST_DONE) && !gnt_id_q;
  assign bus.ack1      = (state_q == ST_DONE) &&  gnt_id_q;
  assign bus.rdata     = rdata_q;
  assign bus.busy      = (state_q != ST_IDLE);

endmodule

// File: doc/rom_rr_arbiter.md
Name: rom_rr_arbiter

Overview:
- Two-requester round-robin arbiter and read sequencer that shares one asynchronous-read 16x4 lookup ROM.
- The ROM has these ports: addr[3:0], cs, rd_en, data_out[3:0].
- Each requester presents a read address. The block drives cs/rd_en/addr for exactly one cycle, registers the ROM data, and returns it with a one-cycle ack pulse.
- It sits between the ROM instance and the two consumer blocks, which must not drive the ROM directly.

Parameters:
- ADDR_W, 4, ROM address width.
- DATA_W, 4, ROM data width.

Ports:
- clk  input  1  rising-edge clock for all state.
- rst  input  1  synchronous, active-high reset.
- req0  input  1  requester 0 read request; held high until ack0 is seen.
- addr0  input  ADDR_W  requester 0 address; stable while req0 is high.
- req1  input  1  requester 1 read request.
- addr1  input  ADDR_W  requester 1 address.
- ack0  output  1  one-cycle pulse: rdata valid for requester 0.
- ack1  output  1  one-cycle pulse: rdata valid for requester 1.
- rdata  output  DATA_W  registered ROM data, valid only while ack0 or ack1 is high.
- busy  output  1  high in every state except IDLE.
- rom_addr  output  ADDR_W  address to the ROM.
- rom_cs  output  1  ROM chip select.
- rom_rd_en  output  1  ROM read enable.
- rom_data  input  DATA_W  ROM data_out, combinational in rom_addr.

Behaviour:
- Clock and reset: single clock; reset is synchronous, active-high on rst.
- Reset values:
  - state=IDLE, ack0=ack1=0, rdata=0, busy=0.
  - rom_cs=rom_rd_en=0, rom_addr=0.
  - last_grant=1, so requester 0 wins the first tie.
- States: IDLE, READ, DONE. All outputs are registered, or decoded from state/latched registers only; there are no combinational req->output paths.
- IDLE:
  - Neither req high: stay in IDLE.
  - Exactly one req high: grant it.
  - Both high: grant the requester that is not last_grant.
  - On a grant, at the edge: latch gnt_id, latch its address into addr_q, update last_grant=gnt_id, go to READ.
- READ (exactly 1 cycle):
  - rom_cs=1, rom_rd_en=1, rom_addr=addr_q.
  - At the edge: rdata<=rom_data, go to DONE.
- DONE (exactly 1 cycle):
  - ack[gnt_id]=1 and rdata is valid. rom_cs=rom_rd_en=0; rom_addr holds addr_q.
  - All req inputs are ignored. Next state is IDLE.
- Requester rule: deassert req no later than the cycle after its ack. A req still high in IDLE after that is treated as a new request.
- Latency: req sampled high in IDLE at edge N -> READ during cycle N+1 -> ack high during cycle N+2.
- Throughput: one read per 3 cycles.
- Starvation bound: a waiting requester is served within 2 transactions (6 cycles) of sampling.
- rom_cs/rom_rd_en are never high outside READ. ack0 and ack1 are never high together.
- rdata holds its last value outside DONE; consumers must qualify it with ack.
- Reset mid-operation (READ or DONE): immediately back to IDLE.
  - Any pending ack is suppressed; rdata=0; last_grant=1.
  - Requests still high after reset are re-arbitrated normally.
- A request arriving while busy=1 waits; it is not lost.
- No address range check: all 2^ADDR_W addresses are forwarded unchanged.

Decomposition:
- Shared include rom_ctrl_defs.vh holds:
  - State encodings: IDLE=2'd0, READ=2'd1, DONE=2'd2. Encoding 2'd3 is illegal and recovers to IDLE.
  - Default ADDR_W/DATA_W values.
- One natural sub-module: rr_arb2.
  - Inputs: req0, req1, last_grant. Outputs: gnt_valid, gnt_id.
  - Purely combinational two-way round-robin pick.
  - The top level owns the FSM, latches and ROM drive.

Test Plan:
- Bench ROM model contents: addr0=4'h3, addr1=4'hB, addr2=4'h6, addr3=4'h1, all other addresses 0.
- Reset: hold rst 2 cycles with req0=1 -> all outputs 0, no rom_cs during reset. First ack0 arrives 2 cycles after rst falls, with rdata=4'h3 (addr0=0).
- Single read: req0=1, addr0=2 in IDLE -> rom_cs=rom_rd_en=1 with rom_addr=2 the next cycle -> ack0=1, rdata=4'h6 the cycle after; ack1 stays 0.
- Tie after reset: req0=1 (addr0=1) and req1=1 (addr1=3) together -> ack0 with 4'hB first, then ack1 with 4'h1 exactly 3 cycles later.
- Fairness: req0 and req1 held continuously, each dropping for one cycle after its ack -> grants alternate 0,1,0,1 over 4 transactions; no requester gets 2 consecutive grants while the other waits.
- Reset mid-operation: assert rst during READ of req1 (addr1=3) -> no ack1 that transaction, state IDLE, rdata=0. With req1 still high, ack1 with 4'h1 arrives 2 cycles after rst deasserts.
- Busy arrival: req1 rises while requester 0's transaction is in READ -> req1 is not dropped; ack1 comes 3 cycles after ack0. rom_cs never overlaps DONE.
